// File: rtl/mont_arb_pkg.sv
// rtl/mont_arb_pkg.sv - shared types and constants for the Montgomery multiplier arbiter
package mont_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_NREQ  = 2;
  localparam int OWNER_W       = $clog2(DEFAULT_NREQ);

  // Owner-id width for a given requester count, never narrower than one bit.
  function automatic int owner_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_arb_rr_pick.sv
// rtl/mont_mul_arb_rr_pick.sv - combinational round-robin selector starting after the pointer
module rr_pick
  import mont_arb_pkg::*;
#(
  parameter int N  = DEFAULT_NREQ,
  parameter int IW = OWNER_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] slot;

  // Scan slots ptr+1 .. ptr+N (mod N); the first requesting slot wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    slot  = '0;
    for (int i = 1; i <= N; i++) begin
      slot = IW'((int'(ptr) + i) % N);
      if (!valid && req[slot]) begin
        valid       = 1'b1;
        grant[slot] = 1'b1;
        idx         = slot;
      end
    end
  end

endmodule

// File: rtl/mont_mul_arb.sv
// rtl/mont_mul_arb.sv - round-robin arbiter sharing one Montgomery multiplier between requesters
module mont_mul_arb
  import mont_arb_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int TIMEOUT = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREQ-1:0]             i_req,
  input  logic [NREQ-1:0][WIDTH-1:0]  i_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  i_b,
  output logic [NREQ-1:0]             o_ack,
  output logic [NREQ-1:0]             o_done,
  output logic                        o_err,
  output logic [WIDTH-1:0]            o_result,
  output logic                        o_busy,
  output logic                        o_mul_start,
  output logic [WIDTH-1:0]            o_mul_a,
  output logic [WIDTH-1:0]            o_mul_b,
  input  logic [WIDTH-1:0]            i_mul_result,
  input  logic                        i_mul_finished
);

  localparam int IDW = owner_w(NREQ);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] WD_MAX  = '1;

  state_t          state;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   wd_cnt;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            wd_expired;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign wd_expired = (TIMEOUT != 0) && (wd_cnt >= WD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= IDW'(NREQ - 1);
      wd_cnt      <= '0;
      o_ack       <= '0;
      o_done      <= '0;
      o_err       <= 1'b0;
      o_result    <= '0;
      o_busy      <= 1'b0;
      o_mul_start <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
    end else begin
      o_ack       <= '0;
      o_done      <= '0;
      o_err       <= 1'b0;
      o_mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            o_mul_a     <= i_a[pick_idx];
            o_mul_b     <= i_b[pick_idx];
            owner       <= pick_idx;
            ptr         <= pick_idx;
            o_ack       <= pick_grant;
            o_mul_start <= 1'b1;
            o_busy      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          // A completion in the same cycle as the watchdog expiry still counts as success.
          if (i_mul_finished) begin
            o_result <= i_mul_result;
            o_done   <= NREQ'(1) << owner;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else if (wd_expired) begin
            o_result <= '0;
            o_done   <= NREQ'(1) << owner;
            o_err    <= 1'b1;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_arb.sv
// tb/tb_mont_mul_arb.sv - self-checking bench for mont_mul_arb and rr_pick
module tb_mont_mul_arb;

  localparam int W = 32;
  localparam int N = 2;
  localparam int T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [N-1:0]         req = '0;
  logic [N-1:0][W-1:0]  a = '0;
  logic [N-1:0][W-1:0]  b = '0;
  logic [N-1:0]         ack, done;
  logic                 err, busy, mul_start;
  logic [W-1:0]         result, mul_a, mul_b;
  logic [W-1:0]         eng_res = '0;
  logic                 eng_fin = 1'b0;
  logic                 fin_force = 1'b0;
  logic                 mul_finished;

  assign mul_finished = eng_fin | fin_force;

  mont_mul_arb #(
    .WIDTH   (W),
    .NREQ    (N),
    .TIMEOUT (T)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_a            (a),
    .i_b            (b),
    .o_ack          (ack),
    .o_done         (done),
    .o_err          (err),
    .o_result       (result),
    .o_busy         (busy),
    .o_mul_start    (mul_start),
    .o_mul_a        (mul_a),
    .o_mul_b        (mul_b),
    .i_mul_result   (eng_res),
    .i_mul_finished (mul_finished)
  );

  logic [3:0] rr_req = '0;
  logic [1:0] rr_ptr = '0;
  logic [3:0] rr_grant;
  logic [1:0] rr_idx;
  logic       rr_valid;

  rr_pick #(
    .N  (4),
    .IW (2)
  ) u_rr (
    .req   (rr_req),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  int lat = 3;
  int rem = 0;
  int eng_lat_op = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Behavioural engine: result = a ^ b, finished pulses lat cycles after start; lat 0 never finishes.
  always @(posedge clk) begin
    #1;
    eng_fin = 1'b0;
    if (rst) begin
      rem = 0;
    end else begin
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) eng_fin = 1'b1;
      end
      if (mul_start) begin
        eng_lat_op = lat;
        eng_res    = mul_a ^ mul_b;
        rem        = lat;
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
  } rr_vec_t;

  typedef struct {
    int         lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int         done_off;
    logic       err;
    logic [W-1:0] res;
  } op_vec_t;

  rr_vec_t rv[9];
  op_vec_t tv[7];

  int           ng, nd0, nd1, g, dd, doff, w, j, m_ptr, m_owner, m_done_cyc, rsel;
  int           grants[8];
  int           gap[N];
  logic         e, pending, idle_prev, m_err, exp_err;
  logic [W-1:0] r, m_res;
  logic [N-1:0] req_prev, exp_ack, exp_done, wait_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  function automatic logic [N-1:0] oh(input int k);
    return N'(1) << k;
  endfunction

  task automatic do_op(input int k, input int l, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int off, output logic oe, output logic [W-1:0] ores);
    lat = l;
    a[k] = av;
    b[k] = bv;
    req[k] = 1'b1;
    tick();
    chk("op_start", mul_start, 1);
    chk("op_ack", ack, oh(k));
    chk("op_mul_a", mul_a, av);
    chk("op_mul_b", mul_b, bv);
    req[k] = 1'b0;
    off  = -1;
    oe   = 1'b0;
    ores = '0;
    for (int i = 1; i <= 40 && off < 0; i++) begin
      tick();
      if (done != 0) begin
        off  = i;
        oe   = err;
        ores = result;
        chk("op_done_owner", done, oh(k));
        chk("op_busy_end", busy, 0);
      end
    end
  endtask

  initial begin
    rv[0] = '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0};
    rv[1] = '{4'b0001, 2'd3, 4'b0001, 2'd0, 1'b1};
    rv[2] = '{4'b0001, 2'd0, 4'b0001, 2'd0, 1'b1};
    rv[3] = '{4'b1111, 2'd0, 4'b0010, 2'd1, 1'b1};
    rv[4] = '{4'b1111, 2'd3, 4'b0001, 2'd0, 1'b1};
    rv[5] = '{4'b1010, 2'd1, 4'b1000, 2'd3, 1'b1};
    rv[6] = '{4'b1010, 2'd3, 4'b0010, 2'd1, 1'b1};
    rv[7] = '{4'b0100, 2'd2, 4'b0100, 2'd2, 1'b1};
    rv[8] = '{4'b1001, 2'd0, 4'b1000, 2'd3, 1'b1};

    tv[0] = '{3,  32'h0000_0005, 32'h0000_0003, 4,  1'b0, 32'h0000_0006};
    tv[1] = '{1,  32'hA5A5_0000, 32'h0000_5A5A, 2,  1'b0, 32'hA5A5_5A5A};
    tv[2] = '{15, 32'hFFFF_0000, 32'h1234_5678, 16, 1'b0, 32'hEDCB_5678};
    tv[3] = '{16, 32'h0F0F_0F0F, 32'h00FF_00FF, 17, 1'b0, 32'h0FF0_0FF0};
    tv[4] = '{17, 32'h0000_0001, 32'h0000_0002, 17, 1'b1, 32'h0000_0000};
    tv[5] = '{0,  32'h0000_0007, 32'h0000_0009, 17, 1'b1, 32'h0000_0000};
    tv[6] = '{2,  32'h0000_C0DE, 32'h0000_00FF, 3,  1'b0, 32'h0000_C021};

    for (int i = 0; i < 9; i++) begin
      rr_req = rv[i].req;
      rr_ptr = rv[i].ptr;
      #1;
      chk("rr_grant", rr_grant, rv[i].grant);
      chk("rr_valid", rr_valid, rv[i].valid);
      if (rv[i].valid) chk("rr_idx", rr_idx, rv[i].idx);
    end

    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_result", result, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    tick();

    // Contention: both requesters from the same cycle, requester 0 first.
    lat  = 3;
    a[0] = 32'h11; b[0] = 32'h22;
    a[1] = 32'h33; b[1] = 32'h0F;
    req  = 2'b11;
    tick();
    chk("cont_ack0", ack, 2'b01);
    chk("cont_start0", mul_start, 1);
    chk("cont_mul_a0", mul_a, 32'h11);
    req[0] = 1'b0;
    repeat (3) tick();
    chk("cont_busy", busy, 1);
    chk("cont_nodone", done, 0);
    tick();
    chk("cont_done0", done, 2'b01);
    chk("cont_res0", result, 32'h33);
    chk("cont_err0", err, 0);
    chk("cont_idle", busy, 0);
    chk("cont_noack", ack, 0);
    tick();
    chk("cont_ack1", ack, 2'b10);
    chk("cont_start1", mul_start, 1);
    chk("cont_mul_b1", mul_b, 32'h0F);
    req[1] = 1'b0;
    repeat (4) tick();
    chk("cont_done1", done, 2'b10);
    chk("cont_res1", result, 32'h3C);

    // Fairness: re-request straight after every done, 8 operations in total.
    lat = 2;
    ng = 0; nd0 = 0; nd1 = 0;
    req = 2'b11;
    for (int c = 0; c < 300 && (nd0 + nd1) < 8; c++) begin
      tick();
      if (ack != 0) begin
        g = ack[1] ? 1 : 0;
        if (ng < 8) grants[ng] = g;
        ng++;
        req[g] = 1'b0;
      end
      if (done != 0) begin
        dd = done[1] ? 1 : 0;
        if (dd == 1) nd1++; else nd0++;
        if (ng + $countones(req) < 8) req[dd] = 1'b1;
      end
    end
    chk("fair_grants", ng, 8);
    for (int i = 0; i < 8; i++) chk("fair_order", grants[i], i % 2);
    chk("fair_done0", nd0, 4);
    chk("fair_done1", nd1, 4);
    req = '0;
    tick();

    // Latency / timeout / same-cycle boundary table on requester 0.
    for (int i = 0; i < 7; i++) begin
      do_op(0, tv[i].lat, tv[i].a, tv[i].b, doff, e, r);
      chk("tv_done_offset", doff, tv[i].done_off);
      chk("tv_err", e, tv[i].err);
      chk("tv_result", r, tv[i].res);
    end

    // Spurious finished while idle.
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    chk("spur_done", done, 0);
    chk("spur_err", err, 0);
    chk("spur_busy", busy, 0);
    chk("spur_result_held", result, 32'h0000_C021);
    tick();
    chk("spur_done2", done, 0);

    // Reset during the second WAIT cycle, then a late finished pulse.
    lat  = 0;
    a[0] = 32'hDEAD; b[0] = 32'hBEEF;
    req[0] = 1'b1;
    tick();
    chk("rw_start", mul_start, 1);
    req[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rw_busy", busy, 0);
    chk("rw_result", result, 0);
    chk("rw_mul_a", mul_a, 0);
    chk("rw_mul_b", mul_b, 0);
    chk("rw_start0", mul_start, 0);
    chk("rw_done", done, 0);
    rst = 1'b0;
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    chk("rw_late_done", done, 0);
    tick();
    chk("rw_late_done2", done, 0);
    chk("rw_idle", busy, 0);
    lat = 2;
    a[1] = 32'h1; b[1] = 32'h2;
    req = 2'b11;
    tick();
    chk("rw_next_grant", ack, 2'b01);

    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Randomised traffic against a transaction-level model.
    m_ptr = N - 1;
    pending = 1'b0;
    idle_prev = 1'b1;
    req_prev = '0;
    wait_done = '0;
    m_owner = 0; m_done_cyc = 0; m_err = 1'b0; m_res = '0;
    for (int k = 0; k < N; k++) gap[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      exp_done = '0;
      exp_err  = 1'b0;
      if (pending && cyc == m_done_cyc) begin
        exp_done = oh(m_owner);
        exp_err  = m_err;
        pending  = 1'b0;
        chk("rnd_result", result, m_res);
      end
      chk("rnd_done", done, exp_done);
      chk("rnd_err", err, exp_err);
      exp_ack = '0;
      if (idle_prev && req_prev != 0) begin
        w = -1;
        for (int i = 1; i <= N; i++) begin
          j = (m_ptr + i) % N;
          if (w < 0 && req_prev[j]) w = j;
        end
        exp_ack = oh(w);
        m_ptr   = w;
        m_owner = w;
        pending = 1'b1;
        if (eng_lat_op == 0 || eng_lat_op > T) begin
          m_done_cyc = cyc + T + 1;
          m_err = 1'b1;
          m_res = '0;
        end else begin
          m_done_cyc = cyc + eng_lat_op + 1;
          m_err = 1'b0;
          m_res = a[w] ^ b[w];
        end
        chk("rnd_mul_a", mul_a, a[w]);
      end
      chk("rnd_ack", ack, exp_ack);
      chk("rnd_start", mul_start, exp_ack != 0);
      chk("rnd_busy", busy, pending);
      idle_prev = !pending;

      for (int k = 0; k < N; k++) begin
        if (ack[k]) begin
          req[k] = 1'b0;
          wait_done[k] = 1'b1;
        end
        if (done[k]) begin
          wait_done[k] = 1'b0;
          gap[k] = $urandom_range(0, 3);
        end
        if (!req[k] && !wait_done[k]) begin
          if (gap[k] > 0) begin
            gap[k]--;
          end else begin
            a[k] = $urandom;
            b[k] = $urandom;
            req[k] = 1'b1;
          end
        end else if (req[k] && $urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
          gap[k] = 1;
        end
      end
      rsel = $urandom_range(0, 9);
      if (rsel == 0) lat = 0;
      else if (rsel == 1) lat = 16;
      else if (rsel == 2) lat = 17;
      else lat = $urandom_range(1, 8);
      req_prev = req;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_mul_arb.md
Name: mont_mul_arb

Overview:
Round-robin arbiter that shares one Montgomery multiplier engine (montMul-style start/finished handshake) between NREQ requesters, e.g. the square and multiply paths of the RSA256 exponentiation core. It registers the winning requester's operands, drives the engine, waits for completion and routes the result back with a per-requester done pulse. A watchdog aborts an engine operation that never finishes. The modulus is wired to the engine separately and is not arbitrated.

Parameters:
WIDTH, 256, operand/result width in bits
NREQ, 2, number of requesters (2..8)
TIMEOUT, 1024, max cycles in WAIT before abort; 0 disables the watchdog

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  NREQ  request level per requester; held with stable operands until o_ack bit seen
i_a  in  NREQ x WIDTH  operand a per requester
i_b  in  NREQ x WIDTH  operand b per requester
o_ack  out  NREQ  one-cycle pulse: request accepted, operands captured
o_done  out  NREQ  one-cycle pulse: result valid for that requester
o_err  out  1  one-cycle pulse coincident with o_done when the operation timed out
o_result  out  WIDTH  result of last completed operation, held until next completion
o_busy  out  1  high in ISSUE/WAIT
o_mul_start  out  1  one-cycle start pulse to engine
o_mul_a  out  WIDTH  registered operand a to engine
o_mul_b  out  WIDTH  registered operand b to engine
i_mul_result  in  WIDTH  engine result
i_mul_finished  in  1  engine completion pulse

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset: state IDLE; o_ack, o_done, o_err, o_mul_start, o_busy = 0; o_result, o_mul_a, o_mul_b = 0; owner id = 0; RR pointer = NREQ-1, so requester 0 has top priority first; watchdog counter = 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: if any i_req, pick the first requester at or after (ptr+1) mod NREQ. Register its a/b into o_mul_a/o_mul_b, store the owner id, set ptr = winner, go ISSUE.
- ISSUE (one cycle): o_mul_start = 1, o_ack[owner] = 1, o_busy = 1; clear the watchdog; go WAIT.
- WAIT: o_busy = 1 and the watchdog increments each cycle.
  - On i_mul_finished: o_result <= i_mul_result, then next cycle o_done[owner] = 1, go IDLE.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without finished: o_result <= 0, then o_done[owner] = 1 and o_err = 1 next cycle, go IDLE.
  - If finished and timeout occur in the same cycle, finished wins with no error.
- Latency:
  - Request high in IDLE at cycle t -> o_mul_start and o_ack at t+1.
  - finished at cycle f -> o_done at f+1.
  - The earliest next grant is sampled at f+1, so the next o_mul_start is at f+2.
- i_mul_finished outside WAIT is ignored.
- A requester may drop i_req before ack (withdrawal); it must not change operands while requesting. Requests arriving while busy wait; there is no queue beyond the level request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
- i_rst mid-operation returns to the reset state immediately. The engine shares i_rst and must be reset with it. No o_done is issued for the aborted operation.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; it does not wrap.

Decomposition:
- Package mont_arb_pkg: state enum (IDLE, ISSUE, WAIT), owner-id width constant $clog2(NREQ), default WIDTH.
- Sub-module rr_pick: combinational round-robin selector (request vector, pointer -> one-hot grant + index, valid). It is instantiated once and unit-tested separately.

Test Plan:
- Single request: behavioural engine with 3-cycle latency and result = a^b; req0 a=0x5, b=0x3 at cycle 10 -> o_mul_start and o_ack[0] at 11, o_done[0] at 15, o_result=0x6, o_err=0.
- Contention: req0 and req1 both held from cycle 10, engine latency 3 -> ack order 0 then 1 (first start 11, second start 16); o_done[0] with its result, then o_done[1]; no overlap of o_busy operations.
- Fairness: both requesters re-request immediately after each done for 8 operations -> grants alternate exactly 0,1,0,1,..; each requester receives 4 done pulses.
- Timeout: TIMEOUT=16, engine never finishes -> o_done[owner] and o_err together 17 cycles after ISSUE; o_result=0; the next request is served normally.
- Reset mid-WAIT: i_rst at cycle 2 of WAIT -> all outputs 0 next cycle; a late i_mul_finished pulse is ignored and produces no o_done; the next grant goes to requester 0.
- Spurious finished in IDLE plus finished and timeout in the same cycle (TIMEOUT=4, latency 4) -> no done in IDLE; for the same-cycle case o_done=1 with o_err=0 and the engine result.
